hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Parametrised pipeline stall/hazard controller for the five-stage core. Successor of the
//   single-lane stall logic: multi-lane decode, a load scoreboard of LOAD_LAT cycles, flush
//   deferral across memory/fetch stalls, and a consecutive-stall counter with timeout flag.
//   Sits beside the pipeline registers; drives IF/ID, ID/EX and EX/MEM hold enables.
// PARAMETERS
//   ISSUE_WIDTH  1   decode lanes checked for load-use (1..2)
//   LOAD_LAT     1   cycles a load result is unforwardable after leaving EX (1..4); 1 = EX-only check
//   CNT_W        8   width of consecutive-stall counter
//   TIMEOUT      0   stall_timeout_o threshold in cycles; 0 disables
// PORTS
//   clk             in   1              clock, rising edge
//   rst             in   1              asynchronous, active-low reset
//   de_rs           in   5*ISSUE_WIDTH  decode-stage rs per lane, lane i at [5i+4:5i]
//   de_rt           in   5*ISSUE_WIDTH  decode-stage rt per lane
//   de_valid        in   ISSUE_WIDTH    lane holds a real instruction
//   ex_mem_type     in   2              EX-stage memory type (`MEM_LOAD/`MEM_STOR/other)
//   ex_rt           in   5              EX-stage load destination
//   if_stall_i      in   1              fetch not ready
//   ex_stall_i      in   1              multi-cycle EX unit busy
//   mem_stall_i     in   1              data access outstanding
//   data_ok         in   1              data access completes this cycle
//   flush_i         in   1              flush request (exception/redirect)
//   if_id_stall_o   out  1              hold IF/ID
//   id_ex_stall_o   out  1              hold ID/EX
//   ex_mem_stall_o  out  1              hold EX/MEM
//   load_use_o      out  1              load-use hazard detected this cycle
//   flush_o         out  1              flush to apply to pipeline this cycle
//   stall_cnt_o     out  CNT_W          consecutive cycles if_id_stall_o has been high
//   stall_timeout_o out  1              stall_cnt_o >= TIMEOUT (TIMEOUT!=0)
// BEHAVIOUR
//   - Reset (rst=0, async): scoreboard slots invalid, FSM IDLE, stall_cnt_o=0, timeout 0.
//     All other outputs combinational; with stall/flush inputs low they read 0.
//   - Scoreboard slot0 (comb) = {ex_mem_type==`MEM_LOAD, ex_rt}. Slots 1..LOAD_LAT-1 registered:
//     when ex_mem_stall_o==0 shift slot[k]<=slot[k-1]; else hold. Not cleared by flush.
//   - load_use_o = OR over valid lanes i, valid slots k: slot.rt!=0 && slot.rt in {rs_i, rt_i}.
//   - Stall state stall_any = if_stall_i|mem_stall_i. FSM states IDLE, PEND:
//       IDLE: flush_i & ~stall_any -> flush_o=1 same cycle, stay IDLE;
//             flush_i &  stall_any -> flush_o=0, go PEND.
//       PEND: ~stall_any -> flush_o=1, go IDLE; else flush_o=0 stay PEND (new flush_i merges).
//   - fl_eff = flush_i | (state==PEND).
//   - if_id_stall_o = ex_stall_i | load_use_o | if_stall_i | mem_stall_i
//   - id_ex_stall_o = if_stall_i | mem_stall_i
//   - ex_mem_stall_o = fl_eff ? if_stall_i : if_stall_i | (mem_stall_i & ~data_ok)
//   - Counter: if_id_stall_o ? cnt+1 saturating at 2^CNT_W-1 : 0. stall_timeout_o registered
//     view of cnt>=TIMEOUT; tied 0 when TIMEOUT==0.
//   - Simultaneous flush_o and load_use_o: both reported; flush has pipeline priority (caller).
// TESTING
//   1 reset mid-stall: cnt=5, PEND -> rst low -> cnt=0, flush_o=0, slots empty immediately.
//   2 LOAD_LAT=3, load rt=8 leaves EX, de_rs=8 two cycles later -> load_use_o=1; third cycle 0.
//   3 ex_rt=0 load, de_rs=0 -> load_use_o=0; lane1 invalid with match -> 0.
//   4 flush_i pulse while mem_stall_i=1 for 3 cycles -> flush_o=0 x3, flush_o=1 on 4th, once.
//   5 mem_stall_i=1,data_ok=1,no flush -> ex_mem_stall_o=0; same with PEND -> ex_mem_stall_o=0.
//   6 TIMEOUT=4, ex_stall_i held 6 cycles -> stall_timeout_o rises after cnt>=4, drops when stall ends.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline stall/hazard controller for the five-stage core: multi-lane
//   load-use detection against a LOAD_LAT-deep load scoreboard, flush
//   deferral while fetch or data access is stalled, and a consecutive-stall
//   counter with an optional timeout flag.
module hazard_stall_ctrl #(
   parameter int unsigned ISSUE_WIDTH = 1,
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned TIMEOUT     = 0,
   // EX-stage memory-type code that marks a load
   parameter logic [1:0]  MEM_LOAD    = 2'b01
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [5*ISSUE_WIDTH-1:0] de_rs,
   input  logic [5*ISSUE_WIDTH-1:0] de_rt,
   input  logic [ISSUE_WIDTH-1:0]   de_valid,
   input  logic [1:0]               ex_mem_type,
   input  logic [4:0]               ex_rt,
   input  logic                     if_stall_i,
   input  logic                     ex_stall_i,
   input  logic                     mem_stall_i,
   input  logic                     data_ok,
   input  logic                     flush_i,
   output logic                     if_id_stall_o,
   output logic                     id_ex_stall_o,
   output logic                     ex_mem_stall_o,
   output logic                     load_use_o,
   output logic                     flush_o,
   output logic [CNT_W-1:0]         stall_cnt_o,
   output logic                     stall_timeout_o
);

   typedef enum logic {
      ST_IDLE,
      ST_PEND
   } state_e;

   typedef struct packed {
      logic       vld;
      logic [4:0] rt;
   } slot_t;

   // Timeout threshold held one bit wider than the counter so a threshold
   // of exactly 2^CNT_W is still representable (never reached).
   localparam logic [CNT_W:0] TO_THR = (CNT_W+1)'(TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             stall_any;
   logic             fl_eff;
   slot_t            slot_all [LOAD_LAT];

   assign stall_any = if_stall_i | mem_stall_i;
   assign fl_eff    = flush_i | (state_q == ST_PEND);

   // Slot 0 is the instruction currently in EX; older loads sit in registers.
   assign slot_all[0] = '{vld: (ex_mem_type == MEM_LOAD), rt: ex_rt};

   if (LOAD_LAT > 1) begin : g_sb
      slot_t sb_q [1:LOAD_LAT-1];

      // Load history shifts with EX/MEM advance; a flush does not clear it.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int unsigned k = 1; k < LOAD_LAT; k++) begin
               sb_q[k] <= '0;
            end
         end else if (!ex_mem_stall_o) begin
            for (int unsigned k = 1; k < LOAD_LAT; k++) begin
               sb_q[k] <= slot_all[k-1];
            end
         end
      end

      for (genvar k = 1; k < LOAD_LAT; k++) begin : g_view
         assign slot_all[k] = sb_q[k];
      end
   end

   // Load-use: any valid lane sourcing a non-zero register still owed by a load.
   always_comb begin
      load_use_o = 1'b0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         for (int unsigned k = 0; k < LOAD_LAT; k++) begin
            if (de_valid[i] && slot_all[k].vld && (slot_all[k].rt != '0) &&
                ((slot_all[k].rt == de_rs[5*i +: 5]) ||
                 (slot_all[k].rt == de_rt[5*i +: 5]))) begin
               load_use_o = 1'b1;
            end
         end
      end
   end

   // Flush deferral: a flush raised during a stall is held until the stall clears.
   always_comb begin
      state_d = state_q;
      flush_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               if (stall_any) begin
                  state_d = ST_PEND;
               end else begin
                  flush_o = 1'b1;
               end
            end
         end
         ST_PEND: begin
            if (!stall_any) begin
               flush_o = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // Pipeline hold enables; a pending flush keeps EX/MEM moving on data-side stalls.
   always_comb begin
      if_id_stall_o  = ex_stall_i | load_use_o | if_stall_i | mem_stall_i;
      id_ex_stall_o  = if_stall_i | mem_stall_i;
      ex_mem_stall_o = fl_eff ? if_stall_i
                              : (if_stall_i | (mem_stall_i & ~data_ok));
   end

   // Consecutive IF/ID stall counter (saturating) and timeout next-state.
   always_comb begin
      if (if_id_stall_o) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end
      tmo_d = (TIMEOUT != 0) && ({1'b0, cnt_d} >= TO_THR);
   end

   // State, counter and timeout flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign stall_cnt_o     = cnt_q;
   assign stall_timeout_o = tmo_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Scoreboard bench for hazard_stall_ctrl (ISSUE_WIDTH=2, LOAD_LAT=3,
//   CNT_W=8, TIMEOUT=4). Each driven cycle pushes the expected outputs,
//   which are popped and compared on the following falling edge.
module tb_hazard_stall_ctrl;

   localparam logic [1:0] LD = 2'b01;
   localparam logic [1:0] ST = 2'b10;
   localparam logic [1:0] NO = 2'b00;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  de_rs, de_rt;
   logic [1:0]  de_valid;
   logic [1:0]  ex_mem_type;
   logic [4:0]  ex_rt;
   logic        if_stall_i, ex_stall_i, mem_stall_i, data_ok, flush_i;
   logic        if_id_stall_o, id_ex_stall_o, ex_mem_stall_o;
   logic        load_use_o, flush_o, stall_timeout_o;
   logic [7:0]  stall_cnt_o;

   typedef struct {
      logic       ifid, idex, exmem, lu, fl, tmo;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q [$];
   int   errors = 0;
   int   checks = 0;

   // reference state
   logic       m_v [1:2];
   logic [4:0] m_r [1:2];
   logic       m_pend;
   logic [7:0] m_cnt;
   logic       m_tmo;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .ISSUE_WIDTH(2),
      .LOAD_LAT(3),
      .CNT_W(8),
      .TIMEOUT(4),
      .MEM_LOAD(LD)
   ) dut (
      .clk(clk), .rst(rst),
      .de_rs(de_rs), .de_rt(de_rt), .de_valid(de_valid),
      .ex_mem_type(ex_mem_type), .ex_rt(ex_rt),
      .if_stall_i(if_stall_i), .ex_stall_i(ex_stall_i),
      .mem_stall_i(mem_stall_i), .data_ok(data_ok), .flush_i(flush_i),
      .if_id_stall_o(if_id_stall_o), .id_ex_stall_o(id_ex_stall_o),
      .ex_mem_stall_o(ex_mem_stall_o), .load_use_o(load_use_o),
      .flush_o(flush_o), .stall_cnt_o(stall_cnt_o),
      .stall_timeout_o(stall_timeout_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // Drive current inputs for one cycle: predict outputs, push, then advance the model.
   task automatic tick();
      exp_t       e;
      logic       sv [0:2];
      logic [4:0] sr [0:2];
      logic       sany, eff;
      logic [7:0] ncnt;
      if (!rst) begin
         m_v[1] = 1'b0; m_v[2] = 1'b0; m_r[1] = '0; m_r[2] = '0;
         m_pend = 1'b0; m_cnt = '0; m_tmo = 1'b0;
      end
      sv[0] = (ex_mem_type == LD); sr[0] = ex_rt;
      sv[1] = m_v[1]; sr[1] = m_r[1];
      sv[2] = m_v[2]; sr[2] = m_r[2];
      e.lu = 1'b0;
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 3; k++) begin
            if (de_valid[i] && sv[k] && sr[k] != 5'd0 &&
                (sr[k] == de_rs[5*i +: 5] || sr[k] == de_rt[5*i +: 5]))
               e.lu = 1'b1;
         end
      end
      sany    = if_stall_i | mem_stall_i;
      eff     = flush_i | m_pend;
      e.fl    = m_pend ? !sany : (flush_i && !sany);
      e.ifid  = ex_stall_i | e.lu | sany;
      e.idex  = sany;
      e.exmem = eff ? if_stall_i : (if_stall_i | (mem_stall_i & ~data_ok));
      e.cnt   = m_cnt;
      e.tmo   = m_tmo;
      exp_q.push_back(e);
      ncnt = e.ifid ? ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1) : 8'd0;
      @(posedge clk);
      if (rst) begin
         if (!e.exmem) begin
            m_v[2] = m_v[1]; m_r[2] = m_r[1];
            m_v[1] = sv[0];  m_r[1] = sr[0];
         end
         m_pend = m_pend ? sany : (flush_i && sany);
         m_cnt  = ncnt;
         m_tmo  = (ncnt >= 8'd4);
      end
      #1;
   endtask

   task automatic idle_inputs();
      de_rs = '0; de_rt = '0; de_valid = '0;
      ex_mem_type = NO; ex_rt = '0;
      if_stall_i = 0; ex_stall_i = 0; mem_stall_i = 0; data_ok = 0; flush_i = 0;
   endtask

   // Compare each expected entry against the DUT away from the rising edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("if_id_stall",  32'(if_id_stall_o),   32'(e.ifid));
         check_eq("id_ex_stall",  32'(id_ex_stall_o),   32'(e.idex));
         check_eq("ex_mem_stall", 32'(ex_mem_stall_o),  32'(e.exmem));
         check_eq("load_use",     32'(load_use_o),      32'(e.lu));
         check_eq("flush",        32'(flush_o),         32'(e.fl));
         check_eq("stall_cnt",    32'(stall_cnt_o),     32'(e.cnt));
         check_eq("timeout",      32'(stall_timeout_o), 32'(e.tmo));
      end
   end

   initial begin
      rst = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      tick(); tick();
      rst = 1'b1;
      tick();

      // load-use window of three cycles after a load leaves EX
      ex_mem_type = LD; ex_rt = 5'd8; tick();
      ex_mem_type = NO; ex_rt = 5'd3; tick();
      de_rs = {5'd0, 5'd8}; de_valid = 2'b01; tick();   // two cycles later: hazard
      tick();                                           // third cycle: clear
      idle_inputs(); tick();

      // x0 never hazards; invalid lane never hazards
      ex_mem_type = LD; ex_rt = 5'd0; de_rs = {5'd0, 5'd0}; de_valid = 2'b11; tick();
      ex_mem_type = LD; ex_rt = 5'd9; de_rs = {5'd9, 5'd1}; de_valid = 2'b01; tick();
      ex_mem_type = ST; ex_rt = 5'd9; de_rs = '0; de_rt = {5'd9, 5'd0}; de_valid = 2'b10; tick();
      idle_inputs(); tick(); tick(); tick();

      // flush during a 3-cycle data stall is deferred, then issued once
      mem_stall_i = 1; flush_i = 1; tick();
      flush_i = 0; tick(); tick();
      mem_stall_i = 0; tick();
      tick(); tick();

      // data_ok releases EX/MEM, with and without a pending flush
      mem_stall_i = 1; data_ok = 1; tick();
      data_ok = 0; tick();
      flush_i = 1; tick();
      flush_i = 0; data_ok = 1; tick();
      data_ok = 0; tick();
      idle_inputs(); tick(); tick();

      // timeout: six cycles of EX busy, then release
      ex_stall_i = 1;
      for (int i = 0; i < 6; i++) tick();
      ex_stall_i = 0; tick(); tick();

      // reset in the middle of a stall with a flush pending
      ex_mem_type = LD; ex_rt = 5'd8; tick();
      ex_mem_type = NO; mem_stall_i = 1; flush_i = 1; tick();
      flush_i = 0;
      for (int i = 0; i < 4; i++) tick();
      de_rs = {5'd0, 5'd8}; de_valid = 2'b01;
      rst = 0; tick();
      idle_inputs(); tick();
      rst = 1; tick();

      // random traffic
      for (int n = 0; n < 300; n++) begin
         de_rs       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         de_rt       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         de_valid    = 2'($urandom_range(0, 3));
         ex_mem_type = 2'($urandom_range(0, 3));
         ex_rt       = 5'($urandom_range(0, 3));
         if_stall_i  = ($urandom_range(0, 5) == 0);
         ex_stall_i  = ($urandom_range(0, 6) == 0);
         mem_stall_i = ($urandom_range(0, 3) == 0);
         data_ok     = ($urandom_range(0, 2) == 0);
         flush_i     = ($urandom_range(0, 6) == 0);
         tick();
      end
      idle_inputs(); tick();

      @(negedge clk); #1;
      check_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
